lcd_sequencer: RTL
==================

# lcd_sequencer

Controller for the HD44780-style character LCD bus, sitting behind the Nios II custom-instruction port. It runs the power-on initialisation sequence itself, then accepts byte commands/data from the processor into a small queue and drains that queue onto the LCD pins. Each byte gets correct setup, enable-pulse and execution-wait timing. The processor never stalls for the full LCD execution time; it stalls only one cycle per push.

## Interface

Parameters:
- `SETUP_CYC`, default 4: cycles RS/data are stable before `enable_op` rises.
- `PULSE_CYC`, default 12: cycles `enable_op` is held high.
- `SHORT_WAIT`, default 2500: post-pulse wait for ordinary commands/data (50 µs at 50 MHz).
- `LONG_WAIT`, default 100000: post-pulse wait for clear/home (2 ms).
- `POWERUP_WAIT`, default 2000000: wait after reset before the first init byte (40 ms).
- `FIFO_DEPTH`, default 8: queue entries; power of two, minimum 2.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `clk_en`, in, 1: custom-instruction clock enable; gates the CI side only.
- `start`, in, 1: custom-instruction start, sampled when `clk_en` is high.
- `dataA`, in, 32: bit 0 = RS of the byte to push; bit 1 = status query (no push).
- `dataB`, in, 32: bits 7:0 = byte to push.
- `done`, out, 1: one-cycle CI completion pulse.
- `result`, out, 32: push status or status word.
- `read_write`, out, 1: tied 0 (write only).
- `register_select`, out, 1: LCD RS.
- `enable_op`, out, 1: LCD E.
- `data_out`, out, 8: LCD DB7..DB0.

## Operation

- **Init ROM** (RS=0): 0x38, 0x0C, 0x06, 0x01. It is issued after `POWERUP_WAIT`, before any queued entry is served.
- **Push**: `start && clk_en && !dataA[1]`.
  - FIFO not full: enqueue {`dataA[0]`, `dataB[7:0]`}; `result` = 0.
  - FIFO full: drop the byte; `result` = 1.
- **Status**: `start && clk_en && dataA[1]`.
  - `result` = {26'b0, ready, busy, count[3:0]}, with count saturated at 15.
  - ready = init complete.
  - busy = state ≠ IDLE or FIFO non-empty.
- **Long-wait bytes**: RS=0 and `data[7:2]`==0 and `data` ≠ 0 (clear/home) use `LONG_WAIT`. All other bytes use `SHORT_WAIT`.
- **FSM states**: POWERUP → INIT_SETUP → PULSE → WAIT → (next ROM byte: INIT_SETUP | ROM exhausted: IDLE).
  - From IDLE: FIFO non-empty → pop, SETUP → PULSE → WAIT → IDLE.
  - SETUP/INIT_SETUP: drive RS/`data_out`, count `SETUP_CYC`.
  - PULSE: `enable_op` = 1 for `PULSE_CYC`.
  - WAIT: `enable_op` = 0, count the selected wait.
- **Outputs between bytes**: RS/`data_out` hold the last byte's values until the next SETUP.
- **Pushes during init** are accepted into the FIFO and served after init.
- **Sequencer independence**: the sequencer runs regardless of `clk_en`.

## Timing

- **Reset values**: `done` 0, `result` 0, `enable_op` 0, `register_select` 0, `data_out` 0x00, `read_write` 0, FIFO empty, state POWERUP, counter 0.
- **Reset mid-byte**: `enable_op` falls at that edge; the queue is flushed and init reruns.
- **CI latency**: `done` is high exactly the cycle after the accepted `start` edge, for one cycle. `result` is valid in that same cycle. `result` holds until the next CI completion.
- **Back-to-back `start`** on consecutive enabled cycles: each gets its own `done`; no request is lost.
- **Per-byte timing**: `enable_op` rises `SETUP_CYC` cycles after the byte appears on the pins. It stays high `PULSE_CYC` cycles. The next byte appears no earlier than wait + 1 cycles after the fall.
- **Pop**: occurs on the IDLE→SETUP edge. An IDLE cycle with a non-empty FIFO always pops on the next edge.
- **Full-FIFO check**: full is evaluated on the registered count before that edge's pop. Push and pop on the same edge with a full FIFO means the push is rejected.
- **Push to an empty FIFO while IDLE**: the byte reaches the pins 2 cycles after `start` (push edge, pop edge).
- **Counters**: 32-bit, compare with `>=` limit−1. Waits are exact to the cycle; there is no wrap.

## Structure

- **`lcd_seq_pkg`** holds:
  - the FSM state enum;
  - the init ROM bytes and length;
  - the CI `dataA` bit positions;
  - the status-word field offsets;
  - the push-result codes (0 ok, 1 full).
- **`lcd_cmd_fifo`** is a separate sub-module: a 9-bit-wide synchronous FIFO with push/pop/full/empty/count. It uses the same `clk` and `reset`.
- **Top level**: the FSM, the counters and the CI handshake.

## Test plan

- **Init sequence**: reset, `POWERUP_WAIT`=20, `SHORT_WAIT`=10, `LONG_WAIT`=40 → four E pulses carrying 0x38, 0x0C, 0x06, 0x01 with RS=0. There are 10/10/10/40 wait cycles after each respectively. Status then reads ready=1, busy=0.
- **Single push after init**: `dataA`=1, `dataB`=0x41 → `done` next cycle, `result`=0. Pins show RS=1 and 0x41 two cycles later. E rises after 4 cycles and stays high 12.
- **Overflow**: 9 pushes 0x30..0x38 during init with depth 8 → first 8 return 0, ninth returns 1. Later the LCD receives exactly 0x30..0x37 in order.
- **Long wait**: push RS=0, 0x01, then RS=1, 0x42 → gap from E fall to the next byte's pins is `LONG_WAIT`+1. Push RS=0, 0x04 → short wait.
- **Reset mid-pulse**: assert reset while E=1 with 3 entries queued → E=0 at the next edge, count=0, POWERUP re-entered, and the init bytes repeat.
- **CI gating**: `start`=1 with `clk_en`=0 → no `done`, no push. Back-to-back enabled pushes → two `done` pulses, both accepted.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the HD44780 LCD sequencer: FSM states, init ROM,
// custom-instruction field positions, status-word layout and push-result codes.
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT_SETUP,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT,
        ST_IDLE
    } seq_state_e;

    localparam int INIT_LEN  = 4;
    localparam int ROM_IDX_W = 2;

    localparam int CI_RS_BIT     = 0;
    localparam int CI_STATUS_BIT = 1;

    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_BUSY_BIT  = 4;
    localparam int STAT_READY_BIT = 5;

    localparam logic [31:0] PUSH_OK   = 32'd0;
    localparam logic [31:0] PUSH_FULL = 32'd1;

    // 8-bit bus, 2 lines; display on; entry mode increment; clear.
    function automatic logic [7:0] init_rom_byte(input logic [ROM_IDX_W-1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous show-ahead FIFO holding {RS, byte} entries between the CI port and
// the LCD sequencer; rdata_o is the head entry whenever the FIFO is non-empty.
module lcd_cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 bus sequencer behind a Nios II custom instruction: runs the power-up init
// ROM, then drains queued bytes with setup / enable-pulse / execution-wait timing.
module lcd_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned PULSE_CYC    = 12,
    parameter int unsigned SHORT_WAIT   = 2500,
    parameter int unsigned LONG_WAIT    = 100000,
    parameter int unsigned POWERUP_WAIT = 2000000,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        done,
    output logic [31:0] result,
    output logic        read_write,
    output logic        register_select,
    output logic        enable_op,
    output logic [7:0]  data_out
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] SETUP_LIM   = 32'(SETUP_CYC) - 32'd1;
    localparam logic [31:0] PULSE_LIM   = 32'(PULSE_CYC) - 32'd1;
    localparam logic [31:0] SHORT_LIM   = 32'(SHORT_WAIT) - 32'd1;
    localparam logic [31:0] LONG_LIM    = 32'(LONG_WAIT) - 32'd1;
    localparam logic [31:0] POWERUP_LIM = 32'(POWERUP_WAIT) - 32'd1;
    localparam logic [ROM_IDX_W-1:0] ROM_LAST = ROM_IDX_W'(INIT_LEN - 1);

    seq_state_e           state_q;
    logic [31:0]          cnt_q;
    logic [ROM_IDX_W-1:0] rom_idx_q;
    logic                 init_done_q;
    logic                 enable_q, rs_q;
    logic [7:0]           data_q;
    logic                 done_q;
    logic [31:0]          result_q;

    logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [8:0]           fifo_rdata;
    logic [CNT_W-1:0]     fifo_count;
    logic                 ci_fire, ci_push;
    logic [31:0]          wait_lim, count_w, status_w;
    logic [3:0]           count_sat;
    logic                 unused_ci;

    assign ci_fire   = start && clk_en;
    assign ci_push   = ci_fire && !dataA[CI_STATUS_BIT];
    assign fifo_push = ci_push && !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign unused_ci = ^{dataA[31:2], dataB[31:8]};

    // The byte on the pins selects its own execution wait.
    assign wait_lim = is_long_cmd(rs_q, data_q) ? LONG_LIM : SHORT_LIM;

    assign count_w   = 32'(fifo_count);
    assign count_sat = (count_w > 32'd15) ? 4'hF : count_w[3:0];

    always_comb begin
        status_w = '0;
        status_w[STAT_COUNT_LSB +: 4] = count_sat;
        status_w[STAT_BUSY_BIT]       = (state_q != ST_IDLE) || !fifo_empty;
        status_w[STAT_READY_BIT]      = init_done_q;
    end

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({dataA[CI_RS_BIT], dataB[7:0]}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_POWERUP;
            cnt_q       <= '0;
            rom_idx_q   <= '0;
            init_done_q <= 1'b0;
            enable_q    <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            unique case (state_q)
                ST_POWERUP: if (cnt_q >= POWERUP_LIM) begin
                    state_q <= ST_INIT_SETUP;
                    cnt_q   <= '0;
                    rs_q    <= 1'b0;
                    data_q  <= init_rom_byte(rom_idx_q);
                end
                ST_INIT_SETUP, ST_SETUP: if (cnt_q >= SETUP_LIM) begin
                    state_q  <= ST_PULSE;
                    cnt_q    <= '0;
                    enable_q <= 1'b1;
                end
                ST_PULSE: if (cnt_q >= PULSE_LIM) begin
                    state_q  <= ST_WAIT;
                    cnt_q    <= '0;
                    enable_q <= 1'b0;
                end
                ST_WAIT: if (cnt_q >= wait_lim) begin
                    cnt_q <= '0;
                    if (!init_done_q && rom_idx_q != ROM_LAST) begin
                        state_q   <= ST_INIT_SETUP;
                        rom_idx_q <= rom_idx_q + 1'b1;
                        rs_q      <= 1'b0;
                        data_q    <= init_rom_byte(rom_idx_q + 1'b1);
                    end else begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!fifo_empty) begin
                        state_q <= ST_SETUP;
                        rs_q    <= fifo_rdata[8];
                        data_q  <= fifo_rdata[7:0];
                    end
                end
                default: begin
                    state_q <= ST_POWERUP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // CI handshake: done follows every enabled start by one cycle; result holds between completions.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= ci_fire;
            if (ci_fire) begin
                if (dataA[CI_STATUS_BIT]) result_q <= status_w;
                else                      result_q <= fifo_full ? PUSH_FULL : PUSH_OK;
            end
        end
    end

    assign done            = done_q;
    assign result          = result_q;
    assign read_write      = 1'b0;
    assign register_select = rs_q;
    assign enable_op       = enable_q;
    assign data_out        = data_q;

endmodule
